// File: rtl/combo_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// combo_sweep_ctrl_pkg
//   Shared definitions for the combinational-datapath sweep controller.
//   - state_e      : sweep FSM states
//   - VEC_W        : width of the applied input vector {a,b,c,d,e}
//   - NUM_VEC      : number of vectors in a full sweep (2**VEC_W)
//   - LAST_VEC     : index of the final vector of a sweep
//   - CNT_W        : width of the settle counter (SETTLE_CYCLES 0..15)
//   - COMBO_GOLDEN : truth table of z = (a&b) | ((c^d)&~e), bit k = z(vector k)
// -----------------------------------------------------------------------------
package combo_sweep_ctrl_pkg;

  localparam int VEC_W   = 5;
  localparam int NUM_VEC = 32;
  localparam int CNT_W   = 4;

  localparam logic [VEC_W-1:0]   LAST_VEC     = VEC_W'(NUM_VEC - 1);
  localparam logic [NUM_VEC-1:0] COMBO_GOLDEN = 32'hFF141414;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/combo_sweep_ctrl_settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
//   Loadable down-counter that times how long a vector is held before its
//   result is sampled. The count saturates at zero; expired_o is high while
//   the count is zero.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset (count cleared)
//   load_i     : load load_val_i into the counter this edge
//   load_val_i : value loaded (number of further cycles before expiry)
//   expired_o  : counter is at zero
// -----------------------------------------------------------------------------
module settle_timer
  import combo_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/combo_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// combo_sweep_ctrl
//   Exhaustively sweeps all 32 input vectors of an external 5-input
//   combinational datapath, captures its output z for each vector into a truth
//   table and compares the result with a golden table latched at start.
//
// Parameters
//   SETTLE_CYCLES : extra cycles each vector is held before sampling (0..15)
//
// Ports
//   clk         : rising-edge clock
//   rst_n       : synchronous active-low reset
//   start       : begin a sweep (honoured only in IDLE, and not with abort)
//   abort       : terminate a sweep in progress
//   expected    : golden truth table, bit k = expected z for vector k
//   vec_out     : vector driven to the datapath, {a,b,c,d,e}, a = MSB
//   z_in        : datapath output for the current vec_out
//   busy        : sweep in progress
//   done        : one-cycle pulse on normal completion
//   pass        : captured table equals latched expected (sticky until start)
//   truth_table : captured z values, bit k = z for vector k
//   fail_valid  : at least one mismatch captured
//   first_fail  : lowest mismatching vector index (valid with fail_valid)
// -----------------------------------------------------------------------------
module combo_sweep_ctrl
  import combo_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [NUM_VEC-1:0] expected,
  output logic [VEC_W-1:0]   vec_out,
  input  logic               z_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] truth_table,
  output logic               fail_valid,
  output logic [VEC_W-1:0]   first_fail
);

  // The HOLD phase covers SETTLE_CYCLES cycles and is followed by one SAMPLE
  // cycle, so every vector is on vec_out for SETTLE_CYCLES+1 cycles. The timer
  // is loaded on HOLD entry with one less than the hold length because the
  // entry cycle itself is the first HOLD cycle.
  localparam logic [CNT_W-1:0] LOAD_VAL =
    (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

  // State in which a new vector begins: with no settle time it is sampled
  // straight away.
  localparam state_e VEC_ENTRY = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_HOLD;

  state_e               state_q, state_d;
  logic [VEC_W-1:0]     vec_q, vec_d;
  logic [NUM_VEC-1:0]   tt_q, tt_d;
  logic [NUM_VEC-1:0]   exp_q, exp_d;
  logic                 pass_q, pass_d;
  logic                 fail_valid_q, fail_valid_d;
  logic [VEC_W-1:0]     first_fail_q, first_fail_d;

  logic                 start_fire;
  logic                 sample_fire;
  logic                 last_vec;
  logic                 timer_load;
  logic                 timer_expired;

  assign last_vec    = (vec_q == LAST_VEC);
  assign start_fire  = (state_q == ST_IDLE) && start && !abort;
  // abort suppresses the capture, including that of the final vector
  assign sample_fire = (state_q == ST_SAMPLE) && !abort;
  assign timer_load  = (state_d == ST_HOLD) && (state_q != ST_HOLD);

  settle_timer #(
    .WIDTH (CNT_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (timer_load),
    .load_val_i (LOAD_VAL),
    .expired_o  (timer_expired)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = VEC_ENTRY;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last_vec) begin
          state_d = ST_DONE;
        end else begin
          state_d = VEC_ENTRY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      ST_HOLD, ST_SAMPLE: busy = 1'b1;
      ST_DONE:            done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sweep datapath: vector counter, capture, compare
  // ---------------------------------------------------------------------------
  always_comb begin
    vec_d        = vec_q;
    tt_d         = tt_q;
    exp_d        = exp_q;
    pass_d       = pass_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;

    if (start_fire) begin
      vec_d        = '0;
      tt_d         = '0;
      exp_d        = expected;
      pass_d       = 1'b0;
      fail_valid_d = 1'b0;
      first_fail_d = '0;
    end else if (sample_fire) begin
      tt_d[vec_q] = z_in;
      // only the first mismatch of a sweep is recorded
      if ((z_in != exp_q[vec_q]) && !fail_valid_q) begin
        fail_valid_d = 1'b1;
        first_fail_d = vec_q;
      end
      if (last_vec) begin
        // vec_out stays at the last vector; the verdict includes this sample
        pass_d = (tt_d == exp_q);
      end else begin
        vec_d = vec_q + VEC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_q        <= '0;
      tt_q         <= '0;
      exp_q        <= '0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
    end else begin
      vec_q        <= vec_d;
      tt_q         <= tt_d;
      exp_q        <= exp_d;
      pass_q       <= pass_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign vec_out     = vec_q;
  assign truth_table = tt_q;
  assign pass        = pass_q;
  assign fail_valid  = fail_valid_q;
  assign first_fail  = first_fail_q;

endmodule

// File: tb/tb_combo_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_combo_sweep_ctrl
//   Self-checking bench for combo_sweep_ctrl. The external datapath is
//   modelled as a 32-entry lookup table indexed by vec_out; the reference
//   model derives the expected sweep outcome from that table and the golden
//   table with whole-word arithmetic.
// -----------------------------------------------------------------------------
module tb_combo_sweep_ctrl;
  import combo_sweep_ctrl_pkg::*;

  localparam int SETTLE = 1;
  localparam int HOLD_LEN = SETTLE + 1;
  localparam int DONE_AT = NUM_VEC * HOLD_LEN;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] expected;
  logic [4:0]  vec_out;
  logic        z_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] truth_table;
  logic        fail_valid;
  logic [4:0]  first_fail;

  logic [31:0] z_tbl;
  logic [31:0] golden_tbl;

  int n_chk;
  int n_fail;

  combo_sweep_ctrl #(
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .expected    (expected),
    .vec_out     (vec_out),
    .z_in        (z_in),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .truth_table (truth_table),
    .fail_valid  (fail_valid),
    .first_fail  (first_fail)
  );

  // external combinational datapath
  assign z_in = z_tbl[vec_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic combo(input logic [4:0] v);
    logic a, b, c, d, e;
    {a, b, c, d, e} = v;
    return (a & b) | ((c ^ d) & ~e);
  endfunction

  function automatic int lowest_set(input logic [31:0] w);
    for (int k = 0; k < 32; k++) begin
      if (w[k]) return k;
    end
    return 0;
  endfunction

  task automatic wait_vec(input logic [4:0] v);
    int n;
    n = 0;
    while (vec_out != v && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (vec_out != v) chk("wait_vec_timeout", 32'(vec_out), 32'(v));
  endtask

  task automatic pulse_start(input logic [31:0] exp_v, input logic [31:0] ztbl);
    z_tbl    = ztbl;
    expected = exp_v;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Full sweep; restart_at >= 0 re-asserts start while vec_out equals it.
  task automatic run_sweep(input logic [31:0] exp_v, input logic [31:0] ztbl,
                           input int restart_at);
    logic [31:0] mism;
    logic [4:0]  prev;
    int          cyc, run, hold_errs, done_cyc;
    mism = ztbl ^ exp_v;
    pulse_start(exp_v, ztbl);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_vec", 32'(vec_out), 32'd0);
    chk("start_tt_clear", truth_table, 32'd0);
    chk("start_fv_clear", 32'(fail_valid), 32'd0);
    chk("start_pass_clear", 32'(pass), 32'd0);
    cyc = 0; run = 1; hold_errs = 0; done_cyc = -1; prev = vec_out;
    while (done_cyc < 0 && cyc < 200) begin
      expected = $urandom;
      start    = (restart_at >= 0) && (vec_out == restart_at[4:0]);
      @(negedge clk);
      cyc++;
      if (done) begin
        done_cyc = cyc;
      end else if (vec_out != prev) begin
        if (run != HOLD_LEN || vec_out != prev + 5'd1) hold_errs++;
        prev = vec_out;
        run  = 1;
      end else begin
        run++;
      end
    end
    start = 1'b0;
    chk("done_cycle", 32'(done_cyc), 32'(DONE_AT));
    chk("hold_len_errs", 32'(hold_errs), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("truth_table", truth_table, ztbl);
    chk("pass", 32'(pass), 32'(mism == 0));
    chk("fail_valid", 32'(fail_valid), 32'(mism != 0));
    if (mism != 0) chk("first_fail", 32'(first_fail), 32'(lowest_set(mism)));
    // start during DONE must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    chk("pass_sticky", 32'(pass), 32'(mism == 0));
  endtask

  // Abort while vec_out == at_vec (in its HOLD cycle, or its SAMPLE cycle).
  task automatic run_abort(input logic [31:0] exp_v, input logic [31:0] ztbl,
                           input logic [4:0] at_vec, input bit at_sample);
    logic [31:0] mask, mism;
    int          dones;
    pulse_start(exp_v, ztbl);
    wait_vec(at_vec);
    if (at_sample) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    mask = (32'h1 << at_vec) - 32'h1;
    mism = (ztbl ^ exp_v) & mask;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tt_partial", truth_table, ztbl & mask);
    chk("abort_pass", 32'(pass), 32'd0);
    chk("abort_fv", 32'(fail_valid), 32'(mism != 0));
    if (mism != 0) chk("abort_first_fail", 32'(first_fail), 32'(lowest_set(mism)));
    dones = 0;
    for (int i = 0; i < 70; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(dones), 32'd0);
  endtask

  initial begin
    logic [31:0] e, z;
    int          ra;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = '0; z_tbl = '0;
    for (int k = 0; k < 32; k++) golden_tbl[k] = combo(k[4:0]);
    repeat (3) @(negedge clk);
    chk("rst_vec", 32'(vec_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_tt", truth_table, 32'd0);
    chk("rst_fv", 32'(fail_valid), 32'd0);
    chk("rst_ff", 32'(first_fail), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    chk("golden_const", golden_tbl, COMBO_GOLDEN);
    run_sweep(COMBO_GOLDEN, golden_tbl, -1);
    run_sweep(32'hFF141410, golden_tbl, -1);
    run_sweep(COMBO_GOLDEN, 32'h0, -1);
    run_sweep(COMBO_GOLDEN, golden_tbl, 10);
    run_abort(COMBO_GOLDEN, golden_tbl, 5'd5, 1'b0);
    run_abort(COMBO_GOLDEN, ~golden_tbl, 5'd31, 1'b1);

    // start together with abort in IDLE
    expected = COMBO_GOLDEN;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("start_abort_idle_done", 32'(done | busy), 32'd0);

    // reset mid-sweep
    pulse_start(COMBO_GOLDEN, golden_tbl);
    wait_vec(5'd20);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_vec", 32'(vec_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_pass", 32'(pass), 32'd0);
    chk("midrst_tt", truth_table, 32'd0);
    chk("midrst_fv", 32'(fail_valid), 32'd0);
    chk("midrst_ff", 32'(first_fail), 32'd0);
    run_sweep(COMBO_GOLDEN, golden_tbl, -1);

    // randomized sweeps
    for (int it = 0; it < 8; it++) begin
      e = $urandom;
      case ($urandom_range(0, 2))
        0:       z = e;
        1:       z = e ^ (32'h1 << $urandom_range(0, 31));
        default: z = $urandom;
      endcase
      ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : -1;
      run_sweep(e, z, ra);
    end
    run_abort($urandom, $urandom, 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
